// File: rtl/mac_pkg.sv
//------------------------------------------------------------------------------
// mac_pkg : shared types and FP16 constants for the MAC result reader
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam int          EXP_W        = 5;
    localparam int          MANT_W       = 10;
    localparam logic [4:0]  EXP_ALL_ONES = 5'h1F;

    localparam logic [1:0]  SPC_NORMAL   = 2'b00;
    localparam logic [1:0]  SPC_INF      = 2'b01;
    localparam logic [1:0]  SPC_NAN      = 2'b10;
    localparam logic [1:0]  SPC_ZERO     = 2'b11;

    // Zero and subnormal share one code: both have an all-zero exponent.
    function automatic logic [1:0] fp16_class(input logic [EXP_W-1:0]  exp_f,
                                              input logic [MANT_W-1:0] mant_f);
        logic [1:0] cls;
        cls = SPC_NORMAL;
        if (exp_f == EXP_ALL_ONES)
            cls = (mant_f == '0) ? SPC_INF : SPC_NAN;
        else if (exp_f == '0)
            cls = SPC_ZERO;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
//------------------------------------------------------------------------------
// result_fifo : synchronous power-of-two FIFO; head reads as zero when empty
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_rd;
    logic             w_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_result_reader.sv
//------------------------------------------------------------------------------
// mac_result_reader : detects end of MAC runs, captures result + length into a
// FIFO. Optional macro RES_FLAG_EN stores an FP16 class code per entry.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_result_reader
    import mac_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 3,
    parameter int DEPTH       = 4,
    parameter int MAC_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mac_enable,
    input  logic [DATA_W-1:0]       acc_result,
    input  logic                    clr_overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [CNT_W-1:0]        out_len,
    output logic [1:0]              out_special,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int                    SETTLE_W = $clog2(MAC_LATENCY + 1);
    localparam logic [SETTLE_W-1:0]   c_LAT    = SETTLE_W'(MAC_LATENCY);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_run_len;
    logic [CNT_W-1:0]      w_run_inc;
    logic [SETTLE_W-1:0]   r_settle_cnt;
    logic                  r_overflow;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;

`ifdef RES_FLAG_EN
    localparam int ENTRY_W = 2 + CNT_W + DATA_W;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    assign w_wdata     = {fp16_class(acc_result[14:10], acc_result[9:0]), r_run_len, acc_result};
    assign out_special = w_rdata[ENTRY_W-1 -: 2];
`else
    localparam int ENTRY_W = CNT_W + DATA_W;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    assign w_wdata     = {r_run_len, acc_result};
    assign out_special = 2'b00;
`endif

    assign out_data  = w_rdata[DATA_W-1:0];
    assign out_len   = w_rdata[DATA_W +: CNT_W];
    assign w_run_inc = (&r_run_len) ? r_run_len : r_run_len + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; re-enable during settle resumes the same run
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (mac_enable) w_state_nxt = ST_ACCUM;
            ST_ACCUM:   if (!mac_enable) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (mac_enable)
                    w_state_nxt = ST_ACCUM;
                else if (r_settle_cnt == c_LAT)
                    w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: w_state_nxt = mac_enable ? ST_ACCUM : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_capture = (r_state == ST_CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_len    <= '0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mac_enable)
                        r_run_len <= CNT_W'(1);
                end
                ST_ACCUM: begin
                    if (mac_enable)
                        r_run_len <= w_run_inc;
                    else
                        r_settle_cnt <= SETTLE_W'(1);
                end
                ST_SETTLE: begin
                    if (mac_enable)
                        r_run_len <= w_run_inc;
                    else if (r_settle_cnt != c_LAT)
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                end
                ST_CAPTURE: begin
                    r_run_len <= mac_enable ? CNT_W'(1) : '0;
                end
                default: begin
                    r_run_len    <= '0;
                    r_settle_cnt <= '0;
                end
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (clr_overflow)
            r_overflow <= 1'b0;
    end

    assign overflow = r_overflow;

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_mac_result_reader.sv
//------------------------------------------------------------------------------
// tb_mac_result_reader : directed stimulus, run-level reference model and
// per-cycle comparison for mac_result_reader
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_result_reader;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;
    localparam int DEPTH  = 4;
    localparam int LAT    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     mac_enable;
    logic [DATA_W-1:0]        acc_result;
    logic                     clr_overflow;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CNT_W-1:0]         out_len;
    logic [1:0]               out_special;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;

    always #5 clk = ~clk;

    mac_result_reader #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .DEPTH       (DEPTH),
        .MAC_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mac_enable   (mac_enable),
        .acc_result   (acc_result),
        .clr_overflow (clr_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_len      (out_len),
        .out_special  (out_special),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] cls_of(input logic [15:0] d);
`ifdef RES_FLAG_EN
        int e;
        int m;
        e = (d >> 10) & 31;
        m = d & 1023;
        if (e == 31) return (m == 0) ? 2'b01 : 2'b10;
        if (e == 0)  return 2'b11;
        return 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    // Reference model: a run ends after LAT+1 consecutive low enables; the
    // following edge captures acc_result and may itself start a new run.
    typedef struct {
        logic [15:0] d;
        logic [2:0]  len;
    } ent_t;

    ent_t q[$];
    bit   m_in_run = 0;
    bit   m_pend   = 0;
    int   m_len    = 0;
    int   m_lows   = 0;
    bit   m_ovf    = 0;

    always @(posedge clk) begin
        bit   pop;
        bit   cap;
        ent_t e;
        if (reset) begin
            q.delete();
            m_in_run = 0; m_pend = 0; m_len = 0; m_lows = 0; m_ovf = 0;
        end else begin
            pop = (q.size() != 0) && out_ready;
            cap = 0;
            e.d = acc_result;
            e.len = 3'(m_len);
            if (m_pend) begin
                cap = 1; m_pend = 0;
                if (mac_enable) begin m_in_run = 1; m_len = 1; m_lows = 0; end
                else m_in_run = 0;
            end else if (m_in_run) begin
                if (mac_enable) begin m_len = (m_len < 7) ? m_len + 1 : 7; m_lows = 0; end
                else begin
                    m_lows++;
                    if (m_lows == LAT + 1) m_pend = 1;
                end
            end else if (mac_enable) begin
                m_in_run = 1; m_len = 1; m_lows = 0;
            end
            if (pop) void'(q.pop_front());
            if (cap && q.size() >= DEPTH) m_ovf = 1;
            else begin
                if (cap) q.push_back(e);
                if (clr_overflow) m_ovf = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("fifo_count", fifo_count, q.size());
            chk("overflow", overflow, m_ovf);
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_len", out_len, q[0].len);
                chk("out_special", out_special, cls_of(q[0].d));
            end else begin
                chk("out_data_empty", out_data, 0);
                chk("out_len_empty", out_len, 0);
                chk("out_special_empty", out_special, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] val, input int n);
        acc_result = val;
        mac_enable = 1'b1;
        tick(n);
        mac_enable = 1'b0;
        tick(LAT + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] t2 [4];
        logic [15:0] t6 [4];
        logic [1:0]  c6 [4];
        t2 = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        t6 = '{16'h7C00, 16'h7E00, 16'h0000, 16'h3C00};
`ifdef RES_FLAG_EN
        c6 = '{2'b01, 2'b10, 2'b11, 2'b00};
`else
        c6 = '{2'b00, 2'b00, 2'b00, 2'b00};
`endif
        reset = 1'b1; mac_enable = 1'b0; acc_result = '0;
        clr_overflow = 1'b0; out_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);

        // Seven-cycle run, drained immediately
        out_ready = 1'b1; acc_result = 16'h4A00; mac_enable = 1'b1;
        tick(7);
        mac_enable = 1'b0;
        tick(3);
        chk("t1_not_yet", out_valid, 0);
        tick(1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 16'h4A00);
        chk("t1_len", out_len, 7);
        tick(1);
        chk("t1_one_beat", out_valid, 0);

        // Five runs into a four-entry FIFO with the consumer stalled
        out_ready = 1'b0;
        run(16'h3C00, 1); run(16'h4000, 1); run(16'h4200, 1);
        run(16'h4400, 1); run(16'h4500, 1);
        chk("t2_count", fifo_count, 4);
        chk("t2_ovf", overflow, 1);
        tick(3);
        chk("t2_hold", out_data, 16'h3C00);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_data", out_data, t2[i]);
            chk("t2_drain_len", out_len, 1);
            tick(1);
        end
        chk("t2_empty", out_valid, 0);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("t2_clr", overflow, 0);

        // Short gap inside the settle window merges into one run
        acc_result = 16'h5000; mac_enable = 1'b1;
        tick(3);
        mac_enable = 1'b0;
        tick(1);
        mac_enable = 1'b1;
        tick(2);
        mac_enable = 1'b0;
        tick(LAT + 2);
        chk("t3_valid", out_valid, 1);
        chk("t3_len", out_len, 5);
        chk("t3_data", out_data, 16'h5000);
        tick(2);
        chk("t3_single", out_valid, 0);

        // Full FIFO, pop coincides with the capture cycle
        out_ready = 1'b0;
        run(16'h1000, 1); run(16'h2000, 1); run(16'h3000, 1); run(16'h4000, 1);
        acc_result = 16'h5000; mac_enable = 1'b1;
        tick(1);
        mac_enable = 1'b0;
        tick(LAT + 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("t4_count", fifo_count, 4);
        chk("t4_ovf", overflow, 0);
        chk("t4_head", out_data, 16'h2000);
        out_ready = 1'b1;
        tick(4);
        chk("t4_tail_len", fifo_count, 0);
        out_ready = 1'b0;

        // Reset during settle with two entries queued
        run(16'h1111, 2); run(16'h2222, 3);
        chk("t5_pre_count", fifo_count, 2);
        acc_result = 16'h3333; mac_enable = 1'b1;
        tick(1);
        mac_enable = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_count", fifo_count, 0);
        tick(6);
        chk("t5_no_capture", fifo_count, 0);

        // FP16 classification of captured values
        run(t6[0], 1); run(t6[1], 1); run(t6[2], 1); run(t6[3], 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_data", out_data, t6[i]);
            chk("t6_special", out_special, c6[i]);
            tick(1);
        end
        chk("t6_empty", out_valid, 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
